// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, phase and fault code definitions
// for the traffic light monitor.
package traffic_light_pkg;

    // Lamp bit positions inside the [0:2] lamp vector.
    localparam int LAMP_G = 0;
    localparam int LAMP_Y = 1;
    localparam int LAMP_R = 2;

    // Index 0 is the leftmost bit of a [0:2] vector, so
    // 3'b100 lights only the green lamp.
    localparam logic [0:2] LEDS_DARK   = 3'b000;
    localparam logic [0:2] LEDS_GREEN  = 3'b100;
    localparam logic [0:2] LEDS_YELLOW = 3'b010;
    localparam logic [0:2] LEDS_RED    = 3'b001;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_GREEN  = 3'd1,
        PH_YELLOW = 3'd2,
        PH_RED    = 3'd3,
        PH_DARK   = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_MULTI   = 3'd1,
        FC_ILLEGAL = 3'd2,
        FC_SHORT   = 3'd3,
        FC_LONG    = 3'd4
    } fault_e;

endpackage

// File: rtl/traffic_light_monitor_tlm_phase_timer.sv
// Saturating phase-length counter with load-to-1 and
// min/max comparators against externally supplied limits.
//   clk, rst  : clock, async active-high reset
//   i_inc     : count one more cycle of the current phase
//   i_load    : new phase starts, counter becomes 1
//   i_min/max : limits for the phase being timed
//   o_cnt     : current count
//   o_short   : count below i_min
//   o_at_max  : count equals i_max (next increment exceeds it)
module tlm_phase_timer
    import traffic_light_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_min,
    input  logic [CNT_W-1:0] i_max,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_short,
    output logic             o_at_max
);

    localparam logic [CNT_W-1:0] SAT = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= ONE;
        end else if (i_inc && r_cnt != SAT) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_short  = r_cnt < i_min;
    // A saturated counter can never step past its limit.
    assign o_at_max = (r_cnt == i_max) && (r_cnt != SAT);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker: tracks the light phase, times each
// phase and latches the first illegal pattern/order/duration.
//   clk, rst        : clock, async active-high reset
//   leds_i          : lamps [0]=green [1]=yellow [2]=red
//   force_red_i     : allows GREEN->RED early exit
//   clear_i         : clears the sticky fault (and stats)
//   phase_o         : tracked phase
//   phase_len_o/vld : length of the phase just ended + pulse
//   cycle_cnt_o     : completed G->Y->R->G cycles
//   fault_o/code_o  : sticky first fault
//   *_max_o         : longest completed phase lengths, only
//                     when TLM_PHASE_STATS_EN is defined
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int GREEN_MIN  = 60,
    parameter int GREEN_MAX  = 200,
    parameter int YELLOW_MIN = 6,
    parameter int YELLOW_MAX = 8,
    parameter int RED_MIN    = 4,
    parameter int RED_MAX    = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:2]       leds_i,
    input  logic             force_red_i,
    input  logic             clear_i,
    output logic [2:0]       phase_o,
    output logic [CNT_W-1:0] phase_len_o,
    output logic             phase_len_vld_o,
    output logic [15:0]      cycle_cnt_o,
    output logic             fault_o,
    output logic [2:0]       fault_code_o,
    output logic [CNT_W-1:0] green_max_o,
    output logic [CNT_W-1:0] yellow_max_o,
    output logic [CNT_W-1:0] red_max_o
);

    localparam logic [2:0] ST_IDLE   = PH_IDLE;
    localparam logic [2:0] ST_GREEN  = PH_GREEN;
    localparam logic [2:0] ST_YELLOW = PH_YELLOW;
    localparam logic [2:0] ST_RED    = PH_RED;
    localparam logic [2:0] ST_DARK   = PH_DARK;

    logic [0:2]       r_leds_q;
    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_len;
    logic             r_vld;
    logic [15:0]      r_cycle;
    logic             r_fault;
    logic [2:0]       r_code;
    // Progress through green->yellow->red: 1=G, 2=Y, 3=R.
    logic [1:0]       r_prog;

    logic [2:0]       w_dec;
    logic             w_multi;
    logic             w_stay;
    logic             w_idle_dark;
    logic             w_change;
    logic             w_pulse;
    logic             w_force_exit;
    logic             w_legal;
    logic             w_timed;
    logic [CNT_W-1:0] w_min;
    logic [CNT_W-1:0] w_max;
    logic [CNT_W-1:0] w_cnt;
    logic             w_short;
    logic             w_at_max;
    logic             w_f_illegal;
    logic             w_f_short;
    logic             w_f_long;
    logic [2:0]       w_code;

    always_comb begin
        w_dec   = ST_DARK;
        w_multi = 1'b0;
        case (r_leds_q)
            LEDS_DARK:   w_dec = ST_DARK;
            LEDS_GREEN:  w_dec = ST_GREEN;
            LEDS_YELLOW: w_dec = ST_YELLOW;
            LEDS_RED:    w_dec = ST_RED;
            default:     w_multi = 1'b1;
        endcase
    end

    // Dark lamps before any phase was seen keep us in IDLE.
    assign w_idle_dark = (r_phase == ST_IDLE) && (w_dec == ST_DARK);
    assign w_stay      = !w_multi && (w_dec == r_phase);
    assign w_change    = !w_multi && (w_dec != r_phase)
                         && !w_idle_dark;
    assign w_pulse     = w_change && (r_phase != ST_IDLE);

    assign w_force_exit = (r_phase == ST_GREEN)
                          && (w_dec == ST_RED) && force_red_i;

    always_comb begin
        w_legal = 1'b0;
        case (r_phase)
            ST_IDLE, ST_DARK:
                w_legal = (w_dec == ST_GREEN)
                          || (w_dec == ST_YELLOW);
            ST_GREEN:
                w_legal = (w_dec == ST_YELLOW)
                          || (w_dec == ST_DARK) || w_force_exit;
            ST_YELLOW:
                w_legal = (w_dec == ST_RED) || (w_dec == ST_DARK);
            ST_RED:
                w_legal = (w_dec == ST_GREEN) || (w_dec == ST_DARK);
            default:
                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_min   = '0;
        w_max   = '1;
        w_timed = 1'b0;
        case (r_phase)
            ST_GREEN: begin
                w_min   = CNT_W'(GREEN_MIN);
                w_max   = CNT_W'(GREEN_MAX);
                w_timed = 1'b1;
            end
            ST_YELLOW: begin
                w_min   = CNT_W'(YELLOW_MIN);
                w_max   = CNT_W'(YELLOW_MAX);
                w_timed = 1'b1;
            end
            ST_RED: begin
                w_min   = CNT_W'(RED_MIN);
                w_max   = CNT_W'(RED_MAX);
                w_timed = 1'b1;
            end
            default: ;
        endcase
    end

    tlm_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stay || w_multi),
        .i_load  (w_change),
        .i_min   (w_min),
        .i_max   (w_max),
        .o_cnt   (w_cnt),
        .o_short (w_short),
        .o_at_max(w_at_max)
    );

    assign w_f_illegal = w_change && !w_legal;
    assign w_f_short   = w_change && w_timed && w_short
                         && (w_dec != ST_DARK) && !w_force_exit;
    assign w_f_long    = (w_stay || w_multi) && w_timed && w_at_max
                         && !((r_phase == ST_RED) && force_red_i);

    always_comb begin
        w_code = FC_NONE;
        if (w_multi)
            w_code = FC_MULTI;
        else if (w_f_illegal)
            w_code = FC_ILLEGAL;
        else if (w_f_short)
            w_code = FC_SHORT;
        else if (w_f_long)
            w_code = FC_LONG;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds_q <= LEDS_DARK;
            r_phase  <= ST_IDLE;
            r_len    <= '0;
            r_vld    <= 1'b0;
            r_cycle  <= '0;
            r_prog   <= 2'd0;
        end else begin
            r_leds_q <= leds_i;
            r_vld    <= w_pulse;
            if (w_pulse)
                r_len <= w_cnt;
            if (w_change) begin
                r_phase <= w_dec;
                if (w_dec == ST_GREEN) begin
                    if (r_phase == ST_RED && r_prog == 2'd3)
                        r_cycle <= r_cycle + 16'd1;
                    r_prog <= 2'd1;
                end else if (r_phase == ST_GREEN
                             && w_dec == ST_YELLOW
                             && r_prog == 2'd1) begin
                    r_prog <= 2'd2;
                end else if (r_phase == ST_YELLOW
                             && w_dec == ST_RED
                             && r_prog == 2'd2) begin
                    r_prog <= 2'd3;
                end else begin
                    r_prog <= 2'd0;
                end
            end
        end
    end

    // A fault seen in the clear cycle is kept, not dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
        end else if (clear_i) begin
            r_fault <= (w_code != FC_NONE);
            r_code  <= w_code;
        end else if (!r_fault && w_code != FC_NONE) begin
            r_fault <= 1'b1;
            r_code  <= w_code;
        end
    end

`ifdef TLM_PHASE_STATS_EN
    logic [CNT_W-1:0] r_gmax;
    logic [CNT_W-1:0] r_ymax;
    logic [CNT_W-1:0] r_rmax;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gmax <= '0;
            r_ymax <= '0;
            r_rmax <= '0;
        end else if (clear_i) begin
            r_gmax <= '0;
            r_ymax <= '0;
            r_rmax <= '0;
        end else if (w_pulse) begin
            if (r_phase == ST_GREEN && w_cnt > r_gmax)
                r_gmax <= w_cnt;
            if (r_phase == ST_YELLOW && w_cnt > r_ymax)
                r_ymax <= w_cnt;
            if (r_phase == ST_RED && w_cnt > r_rmax)
                r_rmax <= w_cnt;
        end
    end

    assign green_max_o  = r_gmax;
    assign yellow_max_o = r_ymax;
    assign red_max_o    = r_rmax;
`else
    assign green_max_o  = '0;
    assign yellow_max_o = '0;
    assign red_max_o    = '0;
`endif

    assign phase_o         = r_phase;
    assign phase_len_o     = r_len;
    assign phase_len_vld_o = r_vld;
    assign cycle_cnt_o     = r_cycle;
    assign fault_o         = r_fault;
    assign fault_code_o    = r_code;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus
// random lamp sequences against a behavioural model.
`timescale 1ns/1ps
module tb_traffic_light_monitor;

    localparam int CNT_W = 12;
    localparam int SATV  = 4095;
`ifdef TLM_PHASE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [0:2]       leds_i = 3'b000;
    logic             force_red_i = 1'b0;
    logic             clear_i = 1'b0;
    logic [2:0]       phase_o;
    logic [CNT_W-1:0] phase_len_o;
    logic             phase_len_vld_o;
    logic [15:0]      cycle_cnt_o;
    logic             fault_o;
    logic [2:0]       fault_code_o;
    logic [CNT_W-1:0] green_max_o;
    logic [CNT_W-1:0] yellow_max_o;
    logic [CNT_W-1:0] red_max_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk            (clk),
        .rst            (rst),
        .leds_i         (leds_i),
        .force_red_i    (force_red_i),
        .clear_i        (clear_i),
        .phase_o        (phase_o),
        .phase_len_o    (phase_len_o),
        .phase_len_vld_o(phase_len_vld_o),
        .cycle_cnt_o    (cycle_cnt_o),
        .fault_o        (fault_o),
        .fault_code_o   (fault_code_o),
        .green_max_o    (green_max_o),
        .yellow_max_o   (yellow_max_o),
        .red_max_o      (red_max_o)
    );

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases as ints: 0 idle, 1 green, 2 yellow, 3 red, 4 dark.
    int  MINL[5] = '{0, 60, 6, 4, 0};
    int  MAXL[5] = '{0, 200, 8, 100, 0};
    bit  LEG[5][5];
    int  m_ph, m_cnt, m_len, m_cyc, m_fault, m_code;
    bit  m_vld;
    int  m_smax[5];
    logic [0:2] m_leds;
    // Phases entered, forced red recorded as 5.
    int  hist[$];

    initial begin
        LEG[0][1] = 1; LEG[0][2] = 1;
        LEG[4][1] = 1; LEG[4][2] = 1;
        LEG[1][2] = 1; LEG[1][4] = 1;
        LEG[2][3] = 1; LEG[2][4] = 1;
        LEG[3][1] = 1; LEG[3][4] = 1;
    end

    function automatic int decode(logic [0:2] v);
        if (v == 3'b000) return 4;
        if ($countones(v) != 1) return -1;
        if (v[0]) return 1;
        if (v[1]) return 2;
        return 3;
    endfunction

    function automatic bit timed(int ph);
        return ph >= 1 && ph <= 3;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_len = 0; m_cyc = 0;
            m_fault = 0; m_code = 0; m_vld = 0;
            m_leds = 3'b000;
            foreach (m_smax[i]) m_smax[i] = 0;
            hist.delete();
        end else begin
            int  dec, code;
            bit  forced;
            dec = decode(m_leds);
            code = 0;
            m_vld = 0;
            if (dec < 0 || dec == m_ph) begin
                m_cnt = (m_cnt < SATV) ? m_cnt + 1 : SATV;
                if (dec < 0)
                    code = 1;
                else if (timed(m_ph) && m_cnt == MAXL[m_ph] + 1
                         && !(m_ph == 3 && force_red_i))
                    code = 4;
            end else if (!(m_ph == 0 && dec == 4)) begin
                forced = (m_ph == 1 && dec == 3 && force_red_i);
                if (!LEG[m_ph][dec] && !forced)
                    code = 2;
                else if (timed(m_ph) && m_cnt < MINL[m_ph]
                         && dec != 4 && !forced)
                    code = 3;
                if (m_ph != 0) begin
                    m_vld = 1;
                    m_len = m_cnt;
                    if (!clear_i && m_cnt > m_smax[m_ph])
                        m_smax[m_ph] = m_cnt;
                end
                if (dec == 1 && m_ph == 3 && hist.size() >= 3
                    && hist[hist.size()-3] == 1
                    && hist[hist.size()-2] == 2
                    && hist[hist.size()-1] == 3)
                    m_cyc = (m_cyc + 1) % 65536;
                hist.push_back(forced ? 5 : dec);
                if (hist.size() > 6) void'(hist.pop_front());
                m_ph = dec;
                m_cnt = 1;
            end
            if (clear_i) begin
                m_fault = (code != 0);
                m_code = code;
                foreach (m_smax[i]) m_smax[i] = 0;
            end else if (m_fault == 0 && code != 0) begin
                m_fault = 1;
                m_code = code;
            end
            m_leds = leds_i;
        end
    end

    always @(negedge clk) begin
        check("phase", int'(phase_o), m_ph);
        check("len", int'(phase_len_o), m_len);
        check("vld", int'(phase_len_vld_o), int'(m_vld));
        check("cycle", int'(cycle_cnt_o), m_cyc);
        check("fault", int'(fault_o), m_fault);
        check("code", int'(fault_code_o), m_code);
        check("gmax", int'(green_max_o), STATS_EN ? m_smax[1] : 0);
        check("ymax", int'(yellow_max_o), STATS_EN ? m_smax[2] : 0);
        check("rmax", int'(red_max_o), STATS_EN ? m_smax[3] : 0);
    end

    int pulses[$];
    always @(negedge clk)
        if (phase_len_vld_o) pulses.push_back(int'(phase_len_o));

    function automatic int pget(int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    function automatic logic [0:2] lamp(int ph);
        logic [0:2] v;
        v = 3'b000;
        if (ph == 1) v[0] = 1'b1;
        if (ph == 2) v[1] = 1'b1;
        if (ph == 3) v[2] = 1'b1;
        return v;
    endfunction

    task automatic hold_c(logic [0:2] v, int n, bit clr);
        for (int i = 0; i < n; i++) begin
            leds_i = v;
            clear_i = clr && (i == 0);
            @(negedge clk);
        end
        clear_i = 1'b0;
    endtask

    task automatic hold(logic [0:2] v, int n);
        hold_c(v, n, 1'b0);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    logic [0:2] G, Y, R, MH;
    logic [0:2] mh[4] = '{3'b110, 3'b101, 3'b011, 3'b111};

    initial begin
        G = lamp(1); Y = lamp(2); R = lamp(3);
        MH = G | Y;
        repeat (3) @(negedge clk);
        check("rst_phase", int'(phase_o), 0);
        check("rst_fault", int'(fault_o), 0);
        check("rst_code", int'(fault_code_o), 0);
        check("rst_cycle", int'(cycle_cnt_o), 0);
        check("rst_vld", int'(phase_len_vld_o), 0);
        rst = 1'b0;
        hold(3'b000, 2);

        // Full legal cycle
        pulses.delete();
        hold(G, 70); hold(Y, 7); hold(R, 5); hold(G, 10);
        check("t1_npulse", pulses.size(), 3);
        check("t1_green", pget(0), 70);
        check("t1_yellow", pget(1), 7);
        check("t1_red", pget(2), 5);
        check("t1_cycle", int'(cycle_cnt_o), 1);
        check("t1_fault", int'(fault_o), 0);
        check("t1_model_cyc", m_cyc, 1);

        // One-cycle multi-hot glitch mid green
        hold(G, 20);
        hold(MH, 1);
        check("t2_lat1", int'(fault_o), 0);
        hold(G, 1);
        check("t2_fault", int'(fault_o), 1);
        check("t2_code", int'(fault_code_o), 1);
        check("t2_phase", int'(phase_o), 1);
        check("t2_model_code", m_code, 1);
        hold(G, 30);
        pulse_clear();
        check("t2_clr_fault", int'(fault_o), 0);
        check("t2_clr_code", int'(fault_code_o), 0);

        // Unforced and forced GREEN->RED
        hold(R, 10);
        check("t3_code", int'(fault_code_o), 2);
        hold(G, 5);
        pulse_clear();
        check("t3_clr", int'(fault_o), 0);
        hold(G, 64);
        force_red_i = 1'b1;
        hold(R, 10);
        force_red_i = 1'b0;
        hold(G, 5);
        check("t3_forced_fault", int'(fault_o), 0);
        check("t3_cycle", int'(cycle_cnt_o), 1);

        // Short yellow
        hold(G, 60); hold(Y, 3); hold(R, 10);
        check("t4_code", int'(fault_code_o), 3);
        check("t4_len", pulses[$], 3);

        // Long green, sticky until clear
        hold(G, 2);
        pulse_clear();
        check("t5_clr", int'(fault_o), 0);
        hold(G, 205);
        check("t5_fault", int'(fault_o), 1);
        check("t5_code", int'(fault_code_o), 4);
        check("t5_model_code", m_code, 4);
        hold(G, 5); hold(Y, 7);
        check("t5_sticky", int'(fault_code_o), 4);
        hold(R, 5);
        pulse_clear();
        check("t5_clr_fault", int'(fault_o), 0);
        check("t5_clr_code", int'(fault_code_o), 0);

        // Asynchronous reset mid green
        hold(G, 40);
        #2 rst = 1'b1;
        #1;
        check("t6_phase", int'(phase_o), 0);
        check("t6_len", int'(phase_len_o), 0);
        check("t6_cycle", int'(cycle_cnt_o), 0);
        check("t6_fault", int'(fault_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses.delete();
        hold(G, 10);
        check("t6_nopulse", pulses.size(), 0);
        check("t6_nofault", int'(fault_o), 0);
        check("t6_green", int'(phase_o), 1);

        // Random lamp sequences
        begin
            int cur;
            cur = 1;
            for (int s = 0; s < 90; s++) begin
                int r, n, nxt;
                bit frc;
                logic [0:2] pat;
                r = $urandom_range(0, 99);
                frc = 1'b0;
                if (r < 6) begin
                    pat = mh[$urandom_range(0, 3)];
                    n = $urandom_range(1, 2);
                    nxt = cur;
                end else begin
                    if (r < 12)
                        nxt = 4;
                    else if (r < 18)
                        nxt = $urandom_range(1, 4);
                    else begin
                        case (cur)
                            1: nxt = ($urandom_range(0, 3) == 0) ? 3 : 2;
                            2: nxt = 3;
                            3: nxt = 1;
                            default: nxt = 1;
                        endcase
                    end
                    if (cur == 1 && nxt == 3)
                        frc = ($urandom_range(0, 3) != 0);
                    if (nxt == 3 && $urandom_range(0, 4) == 0)
                        frc = 1'b1;
                    case (nxt)
                        1: n = $urandom_range(50, 210);
                        2: n = $urandom_range(3, 10);
                        3: n = frc ? $urandom_range(2, 130)
                                   : $urandom_range(2, 110);
                        default: n = $urandom_range(1, 15);
                    endcase
                    pat = lamp(nxt);
                end
                force_red_i = frc;
                hold_c(pat, n, $urandom_range(0, 4) == 0);
                cur = nxt;
            end
            force_red_i = 1'b0;
            hold(G, 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
